spi_master_param: RTL
=====================

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 Parameter DATA_W, default 8: bits per transfer, minimum 2.
REQ-002 Parameter NUM_SS, default 4: number of slave-select lines, minimum 1.
REQ-003 Parameter CLK_DIV, default 4: clk_fpga cycles per sp_clk half-period, minimum 1.
REQ-004 clk_fpga  in  1  sole clock; all logic is rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  single-cycle transfer request.
REQ-007 cpol  in  1  clock polarity, sampled with start.
REQ-008 cpha  in  1  clock phase, sampled with start.
REQ-009 ss_idx  in  max(1,$clog2(NUM_SS))  slave to select, sampled with start.
REQ-010 tx_data  in  DATA_W  word to send, sampled with start.
REQ-011 miso  in  1  serial data from slave.
REQ-012 sp_clk  out  1  serial clock, registered.
REQ-013 mosi  out  1  serial data to slave, registered, MSB first.
REQ-014 ss_n  out  NUM_SS  active-low slave selects, one-hot-low, registered.
REQ-015 busy  out  1  high while a transfer is in progress.
REQ-016 done  out  1  one-cycle pulse at transfer end.
REQ-017 rx_data  out  DATA_W  last received word.

Function
REQ-018 FSM states: IDLE, SETUP, XFER, HOLD.
REQ-019 IDLE: start=1 with ss_idx<NUM_SS latches tx_data, cpol, cpha, ss_idx; next cycle -> SETUP, busy=1, ss_n[ss_idx]=0.
REQ-020 start with ss_idx>=NUM_SS is ignored: no busy, no done.
REQ-021 start while busy=1 is ignored; latched values are unchanged.
REQ-022 SETUP lasts CLK_DIV cycles; sp_clk=cpol; with cpha=0, mosi=tx_data[DATA_W-1] from the first SETUP cycle.
REQ-023 XFER: exactly 2*DATA_W half-periods of CLK_DIV cycles; sp_clk toggles at each boundary, starting at the first XFER cycle.
REQ-024 cpha=0: sample miso on leading (odd) edges; shift next mosi bit on trailing (even) edges, except after the last bit.
REQ-025 cpha=1: shift mosi on leading edges; sample miso on trailing edges.
REQ-026 HOLD lasts CLK_DIV cycles; sp_clk=cpol; ss_n stays asserted.
REQ-027 End of HOLD -> IDLE: ss_n all 1, busy=0, done=1 for one cycle, rx_data updated in the same cycle.
REQ-028 rx_data holds its value until the next done.
REQ-029 Busy duration is (2*DATA_W+2)*CLK_DIV cycles.
REQ-030 start in the done cycle (now IDLE) is accepted, giving back-to-back transfers with ss_n deasserted for exactly one cycle.
REQ-031 In IDLE, sp_clk follows the cpol input with one cycle of delay; mosi=0.
REQ-032 Half-period counter is $clog2(CLK_DIV+1) bits wide; it reloads on every state entry and has no wrap-around beyond CLK_DIV-1.

Reset
REQ-033 rst=1 forces IDLE immediately: sp_clk=0, mosi=0, ss_n=all 1, busy=0, done=0, rx_data=0, all counters and shift registers=0.
REQ-034 rst mid-transfer aborts the transfer: no done pulse, rx_data=0, and no partial word is kept.
REQ-035 After rst falls, the first start is accepted on the first clock edge.

Structure
REQ-036 Shared package spi_pkg holds the FSM state enum and a spi_mode type {cpol,cpha}.
REQ-037 One sub-module, spi_clk_div, generates the half-period tick from CLK_DIV, with a restart input.
REQ-038 Shift registers, FSM and bit counter live in spi_master_param.

Verification
REQ-039 Mode 0, DATA_W=8, CLK_DIV=4; tx=0x45; slave model returns 0x35 -> slave receives 0x45, rx_data=0x35, done pulse 72 cycles after busy rises.
REQ-040 Mode 3, tx=0xF4, slave returns 0x2D -> sp_clk idles at 1, rx_data=0x2D, slave receives 0xF4.
REQ-041 Modes 1 and 2 with tx=0xA5, slave returns 0x5A -> sample/shift edges follow REQ-024/025; rx_data=0x5A.
REQ-042 ss_idx=2, then start re-pulsed mid-transfer with ss_idx=0 and tx=0xFF -> only ss_n[2] is low, the second start is ignored, and exactly one done pulse occurs.
REQ-043 rst at XFER bit 4 -> ss_n=4'b1111 and sp_clk=0 immediately, no done, rx_data=0; next start with tx=0x20 completes normally.
REQ-044 start in the done cycle with tx=0x11 -> second transfer begins, ss_n deasserted one cycle, both words correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the parameterised SPI master: FSM state encoding and the
// clock mode pair captured at the start of each transfer.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: down-counter reloaded with CLK_DIV-1, tick on terminal
// count. restart realigns the count so every FSM state starts a fresh
// half-period.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_fpga,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count down to zero, then reload; restart forces a reload at any point.
  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master, all four clock modes, MSB first.
//
// state    | meaning
// ST_IDLE  | waiting for start; sp_clk tracks cpol input, mosi low
// ST_SETUP | slave selected, one half-period before the first clock edge
// ST_XFER  | 2*DATA_W half-periods, sp_clk toggles at each boundary
// ST_HOLD  | one half-period with the clock idle before deselect
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 4,
  parameter int CLK_DIV = 4,
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_fpga,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [SS_W-1:0]   ss_idx,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sp_clk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int EC_W = $clog2(2 * DATA_W + 1);
  localparam logic [EC_W-1:0]   EDGE_LAST = EC_W'(2 * DATA_W);
  localparam logic [EC_W-1:0]   EDGE_PRE  = EC_W'(2 * DATA_W - 1);
  localparam logic [SS_W:0]     SS_LIMIT  = (SS_W + 1)'(NUM_SS);
  localparam logic [NUM_SS-1:0] SS_ONE    = NUM_SS'(1);

  spi_state_e        state, state_nxt;
  spi_mode_t         mode;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [EC_W-1:0]   edge_cnt;
  logic              tick, restart, accept, do_edge, finish;
  logic              idx_ok, leading;

  // Zero-extended so the range check stays meaningful when NUM_SS is a power of two.
  assign idx_ok  = ({1'b0, ss_idx} < SS_LIMIT);
  assign accept  = (state == ST_IDLE) && start && idx_ok;
  assign restart = (state_nxt != state);
  // edge_cnt holds edges already made, so the next edge is odd (leading) when it is even.
  assign leading = ~edge_cnt[0];

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_fpga (clk_fpga),
    .rst      (rst),
    .restart  (restart),
    .tick     (tick)
  );

  // State register.
  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic plus the per-cycle edge/finish strobes for the datapath.
  always_comb begin
    state_nxt = state;
    do_edge   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SETUP;
      ST_SETUP: if (tick) begin
                  state_nxt = ST_XFER;
                  do_edge   = 1'b1;
                end
      ST_XFER:  if (tick) begin
                  if (edge_cnt == EDGE_LAST) state_nxt = ST_HOLD;
                  else                       do_edge   = 1'b1;
                end
      ST_HOLD:  if (tick) begin
                  state_nxt = ST_IDLE;
                  finish    = 1'b1;
                end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, clock edges with shift/sample, result on finish.
  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      mode     <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      sp_clk   <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        mode     <= '{cpol: cpol, cpha: cpha};
        tx_sr    <= tx_data;
        rx_sr    <= '0;
        edge_cnt <= '0;
        busy     <= 1'b1;
        ss_n     <= ~(SS_ONE << ss_idx);
        sp_clk   <= cpol;
        // With cpha=1 the first bit goes out on the first leading edge instead.
        mosi     <= cpha ? 1'b0 : tx_data[DATA_W-1];
      end else if (state == ST_IDLE) begin
        sp_clk <= cpol;
        mosi   <= 1'b0;
      end
      if (do_edge) begin
        edge_cnt <= edge_cnt + 1'b1;
        sp_clk   <= ~sp_clk;
        if (leading ^ mode.cpha) begin
          rx_sr <= {rx_sr[DATA_W-2:0], miso};
        end else if (mode.cpha) begin
          mosi  <= tx_sr[DATA_W-1];
          tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end else if (edge_cnt != EDGE_PRE) begin
          mosi  <= tx_sr[DATA_W-2];
          tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end
      end
      if (finish) begin
        busy    <= 1'b0;
        ss_n    <= '1;
        sp_clk  <= mode.cpol;
        mosi    <= 1'b0;
        rx_data <= rx_sr;
      end
    end
  end

endmodule
